// File: rtl/dtw_multicore_sched.sv
// Scheduler for a dtw_core array: dispatches host query/reference starts and merges
// the cores' result packets into one sink. Optional counters under DTW_SCHED_STATS_EN.
module dtw_multicore_sched #(
  parameter int NUM_CORES = 4,
  parameter int PKT_WORDS = 3,
  parameter int CW        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_op_mode,
  output logic                     o_start_ready,
  output logic                     o_all_idle,
  output logic [NUM_CORES-1:0]     o_core_start,
  output logic                     o_core_op_mode,
  input  logic [NUM_CORES-1:0]     i_core_running,
  input  logic [NUM_CORES-1:0]     i_core_wren,
  input  logic [32*NUM_CORES-1:0]  i_core_data,
  output logic [NUM_CORES-1:0]     o_core_full,
  output logic                     o_sink_wren,
  output logic [31:0]              o_sink_data,
  input  logic                     i_sink_full,
  output logic [CW-1:0]            o_grant_id
`ifdef DTW_SCHED_STATS_EN
  ,
  output logic [31:0]              o_stat_queries,
  output logic [31:0]              o_stat_packets
`endif
);

  localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_t;

  arb_t                 r_state, w_state_nxt;
  logic [NUM_CORES-1:0] r_pending, r_core_start;
  logic                 r_core_op_mode;
  logic [CW-1:0]        r_rr, r_grant;
  logic [WCW-1:0]       r_word_cnt;
  logic                 r_sink_wren;
  logic [31:0]          r_sink_data;

  logic [NUM_CORES-1:0] w_busy, w_query_sel, w_dispatch;
  logic [CW-1:0]        w_pick, w_idx;
  logic                 w_accept, w_word_acc, w_pkt_done;

  // pending bridges the gap between a start pulse and the core raising running
  assign w_busy        = i_core_running | r_pending;
  assign o_start_ready = i_op_mode ? (~|w_busy && r_state == ARB_IDLE) : ~&w_busy;
  assign w_accept      = i_start & o_start_ready;
  assign w_dispatch    = !w_accept ? '0 : (i_op_mode ? '1 : w_query_sel);

  always_comb begin
    w_query_sel = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_query_sel    = '0;
        w_query_sel[i] = 1'b1;
      end
    end
  end

  // scan downward from the pointer so the last hit is the first requester at/after it
  always_comb begin
    w_pick = r_rr;
    w_idx  = '0;
    for (int k = NUM_CORES-1; k >= 0; k--) begin
      w_idx = (int'(r_rr) + k >= NUM_CORES) ? CW'(int'(r_rr) + k - NUM_CORES)
                                            : CW'(int'(r_rr) + k);
      if (i_core_wren[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    o_core_full = '1;
    if (!i_rst && r_state == ARB_XFER) begin
      for (int i = 0; i < NUM_CORES; i++)
        o_core_full[i] = (CW'(i) != r_grant) | i_sink_full;
    end
  end

  assign w_word_acc = (r_state == ARB_XFER) & i_core_wren[r_grant] & ~i_sink_full;
  assign w_pkt_done = w_word_acc & (r_word_cnt == WCW'(PKT_WORDS-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (|i_core_wren) w_state_nxt = ARB_XFER;
      ARB_XFER: if (w_pkt_done)   w_state_nxt = ARB_IDLE;
      default:                    w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_start   <= '0;
      r_core_op_mode <= 1'b0;
      r_pending      <= '0;
      r_rr           <= '0;
      r_grant        <= '0;
      r_word_cnt     <= '0;
      r_sink_wren    <= 1'b0;
      r_sink_data    <= '0;
    end else begin
      r_core_start <= w_dispatch;
      if (w_accept) r_core_op_mode <= i_op_mode;
      r_pending   <= (r_pending & ~i_core_running) | w_dispatch;
      if (r_state == ARB_IDLE && |i_core_wren) r_grant <= w_pick;
      r_sink_wren <= w_word_acc;
      if (w_word_acc) begin
        r_sink_data <= i_core_data[int'(r_grant)*32 +: 32];
        r_word_cnt  <= w_pkt_done ? '0 : r_word_cnt + 1'b1;
      end
      if (w_pkt_done)
        r_rr <= (r_grant == CW'(NUM_CORES-1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign o_core_start   = r_core_start;
  assign o_core_op_mode = r_core_op_mode;
  assign o_sink_wren    = r_sink_wren;
  assign o_sink_data    = r_sink_data;
  assign o_grant_id     = r_grant;
  assign o_all_idle     = ~|w_busy & (r_state == ARB_IDLE) & ~r_sink_wren;

`ifdef DTW_SCHED_STATS_EN
  logic [31:0] r_stat_q, r_stat_p;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_q <= '0;
      r_stat_p <= '0;
    end else begin
      if (w_accept && !i_op_mode) r_stat_q <= r_stat_q + 32'd1;
      if (w_pkt_done)             r_stat_p <= r_stat_p + 32'd1;
    end
  end

  assign o_stat_queries = r_stat_q;
  assign o_stat_packets = r_stat_p;
`endif

endmodule

// File: tb/tb_dtw_multicore_sched.sv
// Bench for dtw_multicore_sched: directed dispatch/arbitration steps plus randomized
// dispatch and packet traffic checked against a queue-based model of cores and sink.
module tb_dtw_multicore_sched;
  localparam int NC = 4;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0, sink_full = 1'b0;
  logic [NC-1:0]   running = '0, wren = '0;
  logic [32*NC-1:0] cdata = '0;
  logic            start_ready, all_idle, core_op_mode, sink_wren;
  logic [NC-1:0]   core_start, core_full;
  logic [31:0]     sink_data;
  logic [1:0]      grant;
`ifdef DTW_SCHED_STATS_EN
  logic [31:0]     stat_q, stat_p;
`endif

  dtw_multicore_sched #(.NUM_CORES(NC), .PKT_WORDS(3), .CW(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_mode(op),
    .o_start_ready(start_ready), .o_all_idle(all_idle),
    .o_core_start(core_start), .o_core_op_mode(core_op_mode),
    .i_core_running(running), .i_core_wren(wren), .i_core_data(cdata),
    .o_core_full(core_full), .o_sink_wren(sink_wren), .o_sink_data(sink_data),
    .i_sink_full(sink_full), .o_grant_id(grant)
`ifdef DTW_SCHED_STATS_EN
    , .o_stat_queries(stat_q), .o_stat_packets(stat_p)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] cq[NC][$];     // words each modelled core still has to emit
  logic [31:0] exp_q[$];      // directed: exact expected sink order
  logic [31:0] pexp[NC][$];   // random: expected words per source core
  bit  rnd_mode = 1'b0;
  int  rnd_words = 0, cur_src = 0, nwords = 0, nq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: cores present their head word, advance when not held full.
  task automatic step();
    logic [NC-1:0] take;
    int id;
    for (int i = 0; i < NC; i++) begin
      wren[i] = cq[i].size() > 0;
      cdata[32*i +: 32] = 32'h0;
      if (wren[i]) cdata[32*i +: 32] = cq[i][0];
    end
    #2;
    take = wren & ~core_full;
    @(posedge clk);
    for (int i = 0; i < NC; i++) if (take[i]) void'(cq[i].pop_front());
    @(negedge clk);
    if (sink_wren) begin
      nwords++;
      if (!rnd_mode) begin
        if (exp_q.size() == 0) chk("sink_unexpected", 1, 0);
        else chk("sink_data", sink_data, exp_q.pop_front());
      end else begin
        id = int'(sink_data[31:28]);
        if (rnd_words % 3 == 0) cur_src = id;
        chk("no_interleave", id, cur_src);
        if (id >= NC || pexp[id].size() == 0) chk("sink_unexpected_rnd", 1, 0);
        else chk("sink_data_rnd", sink_data, pexp[id].pop_front());
        rnd_words++;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NC; i++) if (cq[i].size() != 0 || pexp[i].size() != 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!all_empty() && n < budget) begin step(); n++; end
    chk("drain_done", all_empty(), 1);
    step();
  endtask

  task automatic push_pkt(input int c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d);
    cq[c].push_back(a); cq[c].push_back(b); cq[c].push_back(d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(d);
  endtask

  initial begin
    logic [3:0] r, exp_start;
    logic [31:0] w;
    int o, n0, seq;
    bit exp_ready;

    // reset behaviour
    @(negedge clk); step();
    chk("full_in_reset", core_full, 4'b1111);
    step();
    rst = 1'b0;
    step();
    chk("rst_core_full", core_full, 4'b1111);
    chk("rst_sink_wren", sink_wren, 0);
    chk("rst_sink_data", sink_data, 0);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_all_idle", all_idle, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_grant", grant, 0);
    chk("rst_op_mode", core_op_mode, 0);

    // two back-to-back queries
    start = 1'b1; op = 1'b0;
    step();
    chk("q1_start", core_start, 4'b0001);
    chk("q1_op", core_op_mode, 0);
    step();
    chk("q2_start", core_start, 4'b0010);
    start = 1'b0;
    nq += 2;
    step();
    chk("q_pulse_end", core_start, 0);
    chk("q_not_idle", all_idle, 0);
    running = 4'b0011; step();
    running = 4'b0000; step();
    chk("q_idle_again", all_idle, 1);

    // reference load blocked by a running core
    running = 4'b0100; op = 1'b1; start = 1'b1;
    #1 chk("ref_blocked_ready", start_ready, 0);
    step();
    chk("ref_blocked_start", core_start, 0);
    running = 4'b0000;
    #1 chk("ref_ready", start_ready, 1);
    step();
    chk("ref_start", core_start, 4'b1111);
    chk("ref_op", core_op_mode, 1);
    start = 1'b0; op = 1'b0;
    running = 4'b1111; step();
    running = 4'b0000; step();

    // cores 1 and 3 together, then core 2, then 0/1/3 (pointer wraps from 3)
    push_pkt(1, 32'h11, 32'h1A0, 32'h07);
    push_pkt(3, 32'h33, 32'h2B0, 32'h05);
    step();
    chk("grant_first", grant, 1);
    drain(40);
    chk("idle_after_pair", all_idle, 1);
    push_pkt(2, 32'h21, 32'h22, 32'h23);
    drain(20);
    push_pkt(3, 32'h31, 32'h32, 32'h34);
    push_pkt(0, 32'h01, 32'h02, 32'h03);
    push_pkt(1, 32'h15, 32'h16, 32'h17);
    drain(60);

    // sink_full stall after the first word
    n0 = nwords;
    push_pkt(0, 32'hA1, 32'hA2, 32'hA3);
    step(); step();
    chk("stall_word1", nwords - n0, 1);
    sink_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_no_wren", sink_wren, 0);
      chk("stall_grant", grant, 0);
      chk("stall_core_hold", cq[0].size(), 2);
    end
    sink_full = 1'b0;
    drain(20);
    chk("stall_total_words", nwords - n0, 3);

    // reset mid-packet drops the remainder and the pointer
    cq[2].push_back(32'hC1); cq[2].push_back(32'hC2); cq[2].push_back(32'hC3);
    exp_q.push_back(32'hC1);
    step(); step();
    rst = 1'b1;
    cq[2].delete();
    step();
    chk("midrst_full", core_full, 4'b1111);
    chk("midrst_wren", sink_wren, 0);
    step();
    rst = 1'b0; nwords = 0; nq = 0;
    step();
    chk("postrst_grant", grant, 0);
    chk("postrst_idle", all_idle, 1);
    chk("postrst_exp_empty", exp_q.size(), 0);
    push_pkt(0, 32'h0A, 32'h0B, 32'h0C);
    push_pkt(3, 32'h3A, 32'h3B, 32'h3C);
    drain(40);

    // random dispatch against lowest-free / all-free rules
    for (int it = 0; it < 24; it++) begin
      running = 4'b1111; step();
      r = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      o = int'($urandom_range(0, 1));
      running = r; op = 1'(o); start = 1'b1;
      exp_ready = (o == 1) ? (r == 4'b0000) : (r != 4'b1111);
      exp_start = 4'b0000;
      if (exp_ready) begin
        if (o == 1) exp_start = 4'b1111;
        else for (int i = NC-1; i >= 0; i--) if (!r[i]) begin exp_start = 4'b0000; exp_start[i] = 1'b1; end
      end
      #1 chk("rnd_ready", start_ready, exp_ready);
      step();
      start = 1'b0;
      chk("rnd_core_start", core_start, exp_start);
      if (exp_ready) chk("rnd_op", core_op_mode, o);
      if (exp_ready && o == 0) nq++;
    end
    op = 1'b0;
    running = 4'b1111; step();
    running = 4'b0000; step();
    chk("rnd_dispatch_idle", all_idle, 1);

    // random packet traffic with random sink backpressure
    rnd_mode = 1'b1; rnd_words = 0; seq = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 7) == 0 && cq[c].size() < 6) begin
          for (int k = 0; k < 3; k++) begin
            w = {4'(c), 28'(seq)}; seq++;
            cq[c].push_back(w); pexp[c].push_back(w);
          end
        end
      end
      sink_full = ($urandom_range(0, 3) == 0);
      step();
    end
    sink_full = 1'b0;
    drain(400);
    chk("rnd_whole_packets", rnd_words % 3, 0);
    chk("rnd_final_idle", all_idle, 1);

`ifdef DTW_SCHED_STATS_EN
    step();
    chk("stat_queries", stat_q, nq);
    chk("stat_packets", stat_p, nwords / 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
